sump_command_receiver: RTL and testbench
========================================

// Module: sump_command_receiver
// PURPOSE
//  Receives host bytes from the serial receiver and decodes the SUMP command stream.
//  Drives the capture configuration (flags, read/delay counts, divider, trigger words)
//  and single-cycle command strobes (run, id_request, soft_reset).
//  Host-to-device counterpart of the RAM-to-serial data path.
// PARAMETERS
//  READ_COUNT_WIDTH  11         width of read_count_x4 (matches the transmitter count port)
//  TIMEOUT_CYCLES    1_000_000  maximum idle gap inside a long command (SUMP_RX_TIMEOUT_EN only)
// PORTS
//  clock               in   1   system clock; all logic on posedge
//  reset_n             in   1   asynchronous active-low reset
//  serial_input_valid  in   1   one-cycle strobe: serial_input_data holds a received byte
//  serial_input_data   in   8   received byte
//  run                 out  1   pulse: start capture
//  id_request          out  1   pulse: host asked for the ID string
//  soft_reset          out  1   pulse: host sent SUMP reset (0x00)
//  config_updated      out  1   pulse: a long command committed
//  command_dropped     out  1   pulse: partial long command discarded on timeout
//  flags               out  16  capture flags
//  read_count_x4       out  RCW samples to read back, in units of 4
//  delay_count_x4      out  16  post-trigger samples, in units of 4
//  divider             out  24  sample clock divider
//  trigger_mask        out  32  trigger mask word
//  trigger_value       out  32  trigger value word
// BEHAVIOUR
//  - Reset values: all pulses 0; flags, divider, trigger_mask and trigger_value are 0.
//    read_count_x4 and delay_count_x4 are 1. The state machine resets to IDLE.
//  - All outputs are registered. Every effect appears on the edge after the edge
//    that samples the byte with valid=1, so latency is 1 cycle. Pulses last exactly 1 cycle.
//  - States: IDLE and ARGS. A 2-bit arg_index and a 32-bit arg shift register hold the arguments.
//  - IDLE, valid byte with bit7 = 0 (short command):
//      0x00 -> soft_reset pulse; all config registers return to their reset values.
//      0x01 -> run pulse.
//      0x02 -> id_request pulse.
//      other values (including XON 0x11 and XOFF 0x13) -> ignored, no output change.
//  - IDLE, valid byte with bit7 = 1: latch the opcode, set arg_index to 0, go to ARGS.
//  - ARGS, valid byte: store it at arg[8*arg_index +: 8] (little-endian).
//      arg_index < 3 -> increment arg_index.
//      arg_index = 3 -> commit, pulse config_updated, go to IDLE.
//  - Commit table, using the full 32-bit argument:
//      0xC0 -> trigger_mask = arg.
//      0xC1 -> trigger_value = arg.
//      0x80 -> divider = arg[23:0].
//      0x81 -> read_count_x4 = sat(arg[15:0] + 1); delay_count_x4 = sat(arg[31:16] + 1).
//      0x82 -> flags = arg[15:0].
//      other opcodes -> the 4 argument bytes are consumed; no register changes;
//      config_updated still pulses.
//  - sat() computes in 17 bits and clamps to the destination's all-ones value.
//    read_count_x4 therefore also clamps at 2^READ_COUNT_WIDTH - 1.
//  - Inside ARGS, 0x00, 0x01 and 0x02 are data bytes, not commands.
//  - valid=0 cycles never change state. Only one byte can arrive per cycle,
//    so command events never collide.
//  - An asynchronous reset_n assertion mid-command aborts the command immediately.
//    Everything returns to reset values, and no pulse is issued.
// CONFIGURATION
//  SUMP_RX_TIMEOUT_EN defined:
//    - A gap counter clears on every valid byte and increments each ARGS cycle without one.
//    - When the counter reaches TIMEOUT_CYCLES with no byte that cycle:
//      return to IDLE, pulse command_dropped, leave config unchanged.
//    - If a byte arrives on the expiry cycle, the byte wins and no timeout occurs.
//  SUMP_RX_TIMEOUT_EN undefined:
//    - No counter; ARGS waits indefinitely for bytes.
//    - command_dropped is tied to 0.
// TESTING
//  1. Bytes 0x01, then 0x02, then 0x7E -> run pulse 1 cycle after the first byte,
//     id_request pulse 1 cycle after the second, no output change for 0x7E.
//  2. Bytes 0x82 05 00 AA BB -> flags = 16'h0005 and config_updated pulses
//     1 cycle after 0xBB; no earlier change.
//  3. Bytes 0x81 FF 01 10 00 -> read_count_x4 = 11'h200 and delay_count_x4 = 16'h0011.
//     Then 0x81 FF FF FF FF -> read_count_x4 = 11'h7FF and delay_count_x4 = 16'hFFFF (saturated).
//  4. Bytes 0xC0 01 00 00 00 (arguments contain 0x00/0x01) -> trigger_mask = 32'h1;
//     no run or soft_reset pulses. A later 0x00 in IDLE -> soft_reset pulse
//     and trigger_mask = 0.
//  5. Bytes 0x82 33 (partial command), then reset_n low for 3 cycles ->
//     all outputs at reset values. After release, byte 0x01 -> run pulse
//     (the parser is back in IDLE).
//  6. With SUMP_RX_TIMEOUT_EN and TIMEOUT_CYCLES = 16:
//     - 0xC1 followed by a 16-cycle gap -> command_dropped pulse;
//       then 0x01 -> run pulse.
//     - Same stimulus without the macro -> no pulse; 0x01 is taken as an
//       argument byte.

Source files
------------

// File: rtl/sump_command_receiver.sv
// sump_command_receiver
//   Decodes the SUMP host command stream arriving one byte at a time from the
//   serial receiver. Short commands (bit7 = 0) produce single-cycle strobes.
//   Long commands (bit7 = 1) take four little-endian argument bytes and then
//   commit a capture configuration register. All outputs are registered, so
//   every effect appears one cycle after the byte is sampled.
//
//   Build option: SUMP_RX_TIMEOUT_EN
//     Enables a gap counter that abandons a partially received long command
//     after TIMEOUT_CYCLES idle cycles and pulses command_dropped. Without it,
//     ARGS waits indefinitely and command_dropped is tied to 0.
//
//   Handshake: serial_input_valid is a one-cycle strobe with no back-pressure.
//   The byte on serial_input_data is consumed on every clock edge where valid
//   is 1; cycles with valid = 0 never change the parser state (apart from the
//   optional gap counter).
module sump_command_receiver #(
    parameter int READ_COUNT_WIDTH = 11,
    parameter int TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        serial_input_valid,
    input  logic [7:0]                  serial_input_data,
    output logic                        run,
    output logic                        id_request,
    output logic                        soft_reset,
    output logic                        config_updated,
    output logic                        command_dropped,
    output logic [15:0]                 flags,
    output logic [READ_COUNT_WIDTH-1:0] read_count_x4,
    output logic [15:0]                 delay_count_x4,
    output logic [23:0]                 divider,
    output logic [31:0]                 trigger_mask,
    output logic [31:0]                 trigger_value
);

    // Elaboration-time sanity checks on the configuration.
    if (READ_COUNT_WIDTH < 1 || READ_COUNT_WIDTH > 16) begin : g_bad_rcw
        $error("READ_COUNT_WIDTH must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        ARGS = 1'b1
    } state_t;

    localparam logic [16:0] RC_MAX = 17'((18'd1 << READ_COUNT_WIDTH) - 18'd1);

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [1:0]  arg_index_q, arg_index_d;
    logic [31:0] arg_q, arg_d;

    logic                        run_d, id_request_d, soft_reset_d, config_updated_d;
    logic [15:0]                 flags_d;
    logic [READ_COUNT_WIDTH-1:0] read_count_d;
    logic [15:0]                 delay_count_d;
    logic [23:0]                 divider_d;
    logic [31:0]                 trigger_mask_d, trigger_value_d;

    logic                        timeout_hit;

    // The final argument byte is committed on the same edge that samples it,
    // so the full argument is the stored three bytes plus the incoming one.
    logic [31:0]                 arg_full;
    logic [16:0]                 rc_sum, dc_sum;
    logic [READ_COUNT_WIDTH-1:0] rc_sat;
    logic [15:0]                 dc_sat;

    assign arg_full = {serial_input_data, arg_q[23:0]};
    assign rc_sum   = {1'b0, arg_full[15:0]} + 17'd1;
    assign dc_sum   = {1'b0, arg_full[31:16]} + 17'd1;
    assign rc_sat   = (rc_sum > RC_MAX) ? RC_MAX[READ_COUNT_WIDTH-1:0]
                                        : rc_sum[READ_COUNT_WIDTH-1:0];
    assign dc_sat   = dc_sum[16] ? 16'hFFFF : dc_sum[15:0];

`ifdef SUMP_RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [GAP_W-1:0] gap_q;

    // Expiry: this is the TIMEOUT_CYCLES-th idle ARGS cycle and no byte came.
    assign timeout_hit = (state_q == ARGS) && !serial_input_valid &&
                         (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

    // Gap counter: clears on any byte or outside ARGS, counts idle ARGS cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_q           <= '0;
            command_dropped <= 1'b0;
        end else begin
            command_dropped <= timeout_hit;
            if (state_q != ARGS || serial_input_valid || timeout_hit) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_q + GAP_W'(1);
            end
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign command_dropped = 1'b0;
`endif

    // Next-state, argument assembly and command decode.
    always_comb begin
        state_d          = state_q;
        opcode_d         = opcode_q;
        arg_index_d      = arg_index_q;
        arg_d            = arg_q;
        run_d            = 1'b0;
        id_request_d     = 1'b0;
        soft_reset_d     = 1'b0;
        config_updated_d = 1'b0;
        flags_d          = flags;
        read_count_d     = read_count_x4;
        delay_count_d    = delay_count_x4;
        divider_d        = divider;
        trigger_mask_d   = trigger_mask;
        trigger_value_d  = trigger_value;

        case (state_q)
            IDLE: begin
                if (serial_input_valid) begin
                    if (serial_input_data[7]) begin
                        opcode_d    = serial_input_data;
                        arg_index_d = 2'd0;
                        state_d     = ARGS;
                    end else begin
                        case (serial_input_data)
                            8'h00: begin
                                soft_reset_d    = 1'b1;
                                flags_d         = 16'h0000;
                                read_count_d    = READ_COUNT_WIDTH'(1);
                                delay_count_d   = 16'h0001;
                                divider_d       = 24'h000000;
                                trigger_mask_d  = 32'h0000_0000;
                                trigger_value_d = 32'h0000_0000;
                            end
                            8'h01:   run_d        = 1'b1;
                            8'h02:   id_request_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ARGS: begin
                if (serial_input_valid) begin
                    arg_d[{arg_index_q, 3'b000} +: 8] = serial_input_data;
                    if (arg_index_q != 2'd3) begin
                        arg_index_d = arg_index_q + 2'd1;
                    end else begin
                        config_updated_d = 1'b1;
                        state_d          = IDLE;
                        case (opcode_q)
                            8'hC0: trigger_mask_d  = arg_full;
                            8'hC1: trigger_value_d = arg_full;
                            8'h80: divider_d       = arg_full[23:0];
                            8'h81: begin
                                read_count_d  = rc_sat;
                                delay_count_d = dc_sat;
                            end
                            8'h82: flags_d = arg_full[15:0];
                            default: ;
                        endcase
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            opcode_q       <= 8'h00;
            arg_index_q    <= 2'd0;
            arg_q          <= 32'h0000_0000;
            run            <= 1'b0;
            id_request     <= 1'b0;
            soft_reset     <= 1'b0;
            config_updated <= 1'b0;
            flags          <= 16'h0000;
            read_count_x4  <= READ_COUNT_WIDTH'(1);
            delay_count_x4 <= 16'h0001;
            divider        <= 24'h000000;
            trigger_mask   <= 32'h0000_0000;
            trigger_value  <= 32'h0000_0000;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            arg_index_q    <= arg_index_d;
            arg_q          <= arg_d;
            run            <= run_d;
            id_request     <= id_request_d;
            soft_reset     <= soft_reset_d;
            config_updated <= config_updated_d;
            flags          <= flags_d;
            read_count_x4  <= read_count_d;
            delay_count_x4 <= delay_count_d;
            divider        <= divider_d;
            trigger_mask   <= trigger_mask_d;
            trigger_value  <= trigger_value_d;
        end
    end

endmodule

// File: tb/tb_sump_command_receiver.sv
// tb_sump_command_receiver
//   Table of {byte, expected outputs} vectors for the main command set, plus
//   hand-written sequences for mid-command reset and the idle-gap behaviour.
//   Inputs change on the falling edge; outputs are checked on the next falling
//   edge, i.e. one cycle after the rising edge that sampled the byte.
module tb_sump_command_receiver;

    localparam int RCW = 11;

    logic            clock;
    logic            reset_n;
    logic            serial_input_valid;
    logic [7:0]      serial_input_data;
    logic            run, id_request, soft_reset, config_updated, command_dropped;
    logic [15:0]     flags;
    logic [RCW-1:0]  read_count_x4;
    logic [15:0]     delay_count_x4;
    logic [23:0]     divider;
    logic [31:0]     trigger_mask, trigger_value;

    int checks = 0;
    int errors = 0;

    sump_command_receiver #(
        .READ_COUNT_WIDTH(RCW),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .serial_input_valid(serial_input_valid),
        .serial_input_data (serial_input_data),
        .run               (run),
        .id_request        (id_request),
        .soft_reset        (soft_reset),
        .config_updated    (config_updated),
        .command_dropped   (command_dropped),
        .flags             (flags),
        .read_count_x4     (read_count_x4),
        .delay_count_x4    (delay_count_x4),
        .divider           (divider),
        .trigger_mask      (trigger_mask),
        .trigger_value     (trigger_value)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // pulse encoding {run, id_request, soft_reset, config_updated}
    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_RUN  = 4'b1000;
    localparam logic [3:0] P_ID   = 4'b0100;
    localparam logic [3:0] P_SRST = 4'b0010;
    localparam logic [3:0] P_UPD  = 4'b0001;

    typedef struct {
        logic           v;
        logic [7:0]     d;
        logic [3:0]     p;
        logic [15:0]    fl;
        logic [RCW-1:0] rc;
        logic [15:0]    dc;
        logic [23:0]    dv;
        logic [31:0]    tm;
        logic [31:0]    tv;
    } vec_t;

    vec_t vecs[$];

    // expected configuration carried into each new table row
    logic [15:0]    e_fl;
    logic [RCW-1:0] e_rc;
    logic [15:0]    e_dc;
    logic [23:0]    e_dv;
    logic [31:0]    e_tm, e_tv;

    task automatic exp_reset_cfg();
        e_fl = 16'h0000; e_rc = 11'h001; e_dc = 16'h0001;
        e_dv = 24'h0;    e_tm = 32'h0;   e_tv = 32'h0;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [3:0] p);
        vec_t r;
        r.v = v; r.d = d; r.p = p;
        r.fl = e_fl; r.rc = e_rc; r.dc = e_dc; r.dv = e_dv; r.tm = e_tm; r.tv = e_tv;
        vecs.push_back(r);
    endtask

    // scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic [3:0] p, input logic drop);
        chk({tag, "_pulses"}, {28'h0, run, id_request, soft_reset, config_updated}, {28'h0, p});
        chk({tag, "_dropped"}, {31'h0, command_dropped}, {31'h0, drop});
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_flags"},   {16'h0, flags},          {16'h0, e_fl});
        chk({tag, "_rcount"},  {21'h0, read_count_x4},  {21'h0, e_rc});
        chk({tag, "_dcount"},  {16'h0, delay_count_x4}, {16'h0, e_dc});
        chk({tag, "_divider"}, {8'h0, divider},         {8'h0, e_dv});
        chk({tag, "_tmask"},   trigger_mask,            e_tm);
        chk({tag, "_tvalue"},  trigger_value,           e_tv);
    endtask

    // driver: present one cycle of input, then wait to the sampling point
    task automatic step(input logic v, input logic [7:0] d);
        serial_input_valid = v;
        serial_input_data  = d;
        @(negedge clock);
    endtask

    initial begin
        reset_n            = 1'b0;
        serial_input_valid = 1'b0;
        serial_input_data  = 8'h00;
        exp_reset_cfg();

        // ---- build vector table ----
        // short commands, XON/XOFF ignored, idle cycle
        add(1, 8'h01, P_RUN);
        add(1, 8'h02, P_ID);
        add(1, 8'h7E, P_NONE);
        add(1, 8'h11, P_NONE);
        add(1, 8'h13, P_NONE);
        add(0, 8'h01, P_NONE);
        // flags; 0x00 inside ARGS is data
        add(1, 8'h82, P_NONE);
        add(1, 8'h05, P_NONE);
        add(1, 8'h00, P_NONE);
        add(1, 8'hAA, P_NONE);
        e_fl = 16'h0005;
        add(1, 8'hBB, P_UPD);
        add(0, 8'h00, P_NONE);
        // read/delay counts with saturation
        add(1, 8'h81, P_NONE); add(1, 8'hFF, P_NONE); add(1, 8'h01, P_NONE); add(1, 8'h10, P_NONE);
        e_rc = 11'h200; e_dc = 16'h0011;
        add(1, 8'h00, P_UPD);
        add(1, 8'h81, P_NONE); add(1, 8'hFF, P_NONE); add(1, 8'h07, P_NONE); add(1, 8'h00, P_NONE);
        e_rc = 11'h7FF; e_dc = 16'h0001;
        add(1, 8'h00, P_UPD);
        add(1, 8'h81, P_NONE); add(1, 8'hFE, P_NONE); add(1, 8'h03, P_NONE); add(1, 8'hFE, P_NONE);
        e_rc = 11'h3FF; e_dc = 16'hFFFF;
        add(1, 8'hFF, P_UPD);
        add(1, 8'h81, P_NONE); add(1, 8'hFF, P_NONE); add(1, 8'hFF, P_NONE); add(1, 8'hFF, P_NONE);
        e_rc = 11'h7FF; e_dc = 16'hFFFF;
        add(1, 8'hFF, P_UPD);
        // divider with idle cycles mid-argument (data on idle cycles ignored)
        add(1, 8'h80, P_NONE); add(1, 8'h56, P_NONE); add(0, 8'h77, P_NONE);
        add(1, 8'h34, P_NONE); add(0, 8'h01, P_NONE); add(1, 8'h12, P_NONE);
        e_dv = 24'h123456;
        add(1, 8'h9A, P_UPD);
        // trigger mask with 0x01/0x00 argument bytes
        add(1, 8'hC0, P_NONE); add(1, 8'h01, P_NONE); add(1, 8'h00, P_NONE); add(1, 8'h00, P_NONE);
        e_tm = 32'h0000_0001;
        add(1, 8'h00, P_UPD);
        // trigger value
        add(1, 8'hC1, P_NONE); add(1, 8'h02, P_NONE); add(1, 8'h01, P_NONE); add(1, 8'h00, P_NONE);
        e_tv = 32'h8000_0102;
        add(1, 8'h80, P_UPD);
        // unknown opcode: consumes 4 bytes, pulses update only
        add(1, 8'hA5, P_NONE); add(1, 8'h01, P_NONE); add(1, 8'h02, P_NONE); add(1, 8'h03, P_NONE);
        add(1, 8'h04, P_UPD);
        // soft reset restores config, then parser still alive
        exp_reset_cfg();
        add(1, 8'h00, P_SRST);
        add(1, 8'h01, P_RUN);
        add(0, 8'h00, P_NONE);

        // ---- reset state ----
        @(negedge clock);
        @(negedge clock);
        chk_pulses("rst_held", P_NONE, 1'b0);
        chk_cfg("rst_held");
        reset_n = 1'b1;
        @(negedge clock);
        chk_pulses("rst_released", P_NONE, 1'b0);
        chk_cfg("rst_released");

        // ---- table ----
        e_fl = 'x;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d);
            e_fl = vecs[i].fl; e_rc = vecs[i].rc; e_dc = vecs[i].dc;
            e_dv = vecs[i].dv; e_tm = vecs[i].tm; e_tv = vecs[i].tv;
            chk_pulses($sformatf("vec%0d", i), vecs[i].p, 1'b0);
            chk_cfg($sformatf("vec%0d", i));
        end

        // ---- mid-command asynchronous reset ----
        exp_reset_cfg();
        step(1, 8'h82); step(1, 8'h0F); step(1, 8'h00); step(1, 8'h00); step(1, 8'h00);
        e_fl = 16'h000F;
        chk_pulses("flags_f", P_UPD, 1'b0);
        chk_cfg("flags_f");
        step(1, 8'h82);
        step(1, 8'h33);
        chk_pulses("partial", P_NONE, 1'b0);
        serial_input_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        exp_reset_cfg();
        chk_pulses("async_rst", P_NONE, 1'b0);
        chk_cfg("async_rst");
        @(negedge clock); @(negedge clock); @(negedge clock);
        chk_pulses("rst3", P_NONE, 1'b0);
        chk_cfg("rst3");
        reset_n = 1'b1;
        @(negedge clock);
        step(1, 8'h01);
        chk_pulses("after_rst_run", P_RUN, 1'b0);
        chk_cfg("after_rst_run");
        step(0, 8'h00);
        chk_pulses("after_rst_idle", P_NONE, 1'b0);

        // ---- idle gap inside a long command ----
        step(1, 8'hC1);
        chk_pulses("gap_op", P_NONE, 1'b0);
`ifdef SUMP_RX_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            step(0, 8'h00);
            chk_pulses($sformatf("gap%0d", k), P_NONE, (k == 16));
        end
        step(1, 8'h01);
        chk_pulses("gap_run", P_RUN, 1'b0);
        chk_cfg("gap_run");
`else
        for (int k = 1; k <= 16; k++) begin
            step(0, 8'h00);
            chk_pulses($sformatf("gap%0d", k), P_NONE, 1'b0);
        end
        step(1, 8'h01);
        chk_pulses("gap_arg0", P_NONE, 1'b0);
        step(1, 8'h00);
        step(1, 8'h00);
        chk_pulses("gap_arg2", P_NONE, 1'b0);
        step(1, 8'h80);
        e_tv = 32'h8000_0001;
        chk_pulses("gap_commit", P_UPD, 1'b0);
        chk_cfg("gap_commit");
`endif
        step(0, 8'h00);
        chk_pulses("final_idle", P_NONE, 1'b0);

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
